uart_tx_arbiter: RTL and testbench

- Round-robin arbiter sharing one uart transmitter (32-bit data_in / start / tx_done handshake) between NUM_REQ requesters.
- Latches the winning word, holds start high until the uart signals tx_done, then enforces an inter-frame gap before the next grant.
- Sits between the requesting clients and the uart instance; owns the uart's data_in and start inputs exclusively.

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart transmitter between NUM_REQ clients.
// Latches the winning word, holds start until tx_done rises, then enforces an inter-frame gap.
module uart_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int GAP_CYCLES     = 5,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int GRANT_W        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     timeout_err,
  output logic [31:0]            uart_data_in,
  output logic                   uart_start,
  input  logic                   uart_tx_done,
  output logic                   busy,
  output logic [GRANT_W-1:0]     grant_id
);

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;

  logic [31:0]          r_data;
  logic                 r_start;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   r_toerr;
  logic [15:0]          r_to_cnt;
  logic [15:0]          r_gap_cnt;
  logic                 r_tx_done_q;

  logic [31:0]          w_req_word [NUM_REQ];
  logic                 w_any_valid;
  logic [GRANT_W-1:0]   w_winner;
  logic [GRANT_W-1:0]   w_idx;
  logic [NUM_REQ-1:0]   w_winner_oh;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_gap_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_word[g] = req_data[32*g +: 32];
  end

  // Search starts just above the last winner so every client gets a turn.
  // NOTE: every variable gets a default at the top of an always_comb, so no path can infer a latch.
  always_comb begin
    w_any_valid = 1'b0;
    w_winner    = '0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GRANT_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_any_valid && req_valid[w_idx]) begin
        w_any_valid = 1'b1;
        w_winner    = w_idx;
      end
    end
  end

  assign w_winner_oh = NUM_REQ'(1) << w_winner;
  assign w_grant_oh  = NUM_REQ'(1) << r_grant;

  // Only a rising tx_done ends a frame; a level left over from the previous frame is ignored.
  assign w_complete = (r_state == ST_SEND) && uart_tx_done && !r_tx_done_q;
  assign w_timeout  = (r_state == ST_SEND) && (TIMEOUT_CYCLES != 0) &&
                      (r_to_cnt == TO_LAST) && !w_complete;
  assign w_gap_done = (r_gap_cnt == GAP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_complete || w_timeout) w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_start      <= 1'b0;
      r_grant      <= '0;
      r_last_grant <= GRANT_W'(NUM_REQ - 1);
      r_done       <= '0;
      r_toerr      <= '0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_tx_done_q  <= 1'b0;
    end else begin
      r_tx_done_q <= uart_tx_done;
      r_done      <= '0;
      r_toerr     <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_data       <= w_req_word[w_winner];
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_start      <= 1'b1;
            r_to_cnt     <= '0;
          end
        end
        ST_SEND: begin
          r_to_cnt <= r_to_cnt + 16'd1;
          if (w_complete) begin
            r_start   <= 1'b0;
            r_done    <= w_grant_oh;
            r_gap_cnt <= '0;
          end else if (w_timeout) begin
            r_start   <= 1'b0;
            r_toerr   <= w_grant_oh;
            r_gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt + 16'd1;
        end
        default: begin
          r_start <= 1'b0;
        end
      endcase
    end
  end

  // req_ready is forced low while reset is held, even though the state already reads IDLE.
  assign req_ready    = (rst_n && (r_state == ST_IDLE)) ? w_winner_oh : '0;
  assign busy         = (r_state != ST_IDLE);
  assign uart_start   = r_start;
  assign uart_data_in = r_data;
  assign grant_id     = r_grant;
  assign req_done     = r_done;
  assign timeout_err  = r_toerr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round robin, timeout,
// stale tx_done, reset mid-frame and a randomized multi-requester stream.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 5;
  localparam int TO  = 100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_done;
  logic [NR-1:0]   timeout_err;
  logic [31:0]     uart_data_in;
  logic            uart_start;
  logic            uart_tx_done;
  logic            busy;
  logic [1:0]      grant_id;

  logic            auto_uart   = 1'b0;
  logic            man_done    = 1'b0;
  logic            r_auto_done = 1'b0;
  int              lat         = 0;
  logic [31:0]     rx_q [$];
  int              done_cnt    = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign uart_tx_done = auto_uart ? r_auto_done : man_done;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .req_done     (req_done),
    .timeout_err  (timeout_err),
    .uart_data_in (uart_data_in),
    .uart_start   (uart_start),
    .uart_tx_done (uart_tx_done),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  // Behavioural uart: a few clocks after start it raises tx_done and records the word it sent.
  always @(posedge clk) begin
    #2;
    if (!auto_uart || !uart_start) begin
      r_auto_done = 1'b0;
      lat = 0;
    end else if (!r_auto_done) begin
      if (lat == 3) begin
        r_auto_done = 1'b1;
        rx_q.push_back(uart_data_in);
      end else begin
        lat++;
      end
    end
  end

  always @(negedge clk) if (req_done != '0) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (uart_start !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (uart_start !== 1'b1) begin
      $display("FAIL %s: uart_start wait expired, got %b want 1", tag, uart_start); errors++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL %s: busy wait expired, got %b want 0", tag, busy); errors++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_data = '0;
    repeat (5) tick();
    checks++; if (req_ready !== 4'h0) begin $display("FAIL reset_ready: got %h want 0", req_ready); errors++; end
    checks++; if (uart_start !== 1'b0) begin $display("FAIL reset_start: got %b want 0", uart_start); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); errors++; end
    checks++; if (req_done !== 4'h0) begin $display("FAIL reset_done: got %h want 0", req_done); errors++; end
    checks++; if (timeout_err !== 4'h0) begin $display("FAIL reset_toerr: got %h want 0", timeout_err); errors++; end
    checks++; if (grant_id !== 2'd0) begin $display("FAIL reset_grant: got %0d want 0", grant_id); errors++; end
    checks++; if (uart_data_in !== 32'h0) begin $display("FAIL reset_data: got %h want 0", uart_data_in); errors++; end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n = 0;
    int pulses = 0;
    req_data[95:64] = 32'hDEADBEEF;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin $display("FAIL single_ready: got %b want 0100", req_ready); errors++; end
    tick();
    checks++; if (uart_start !== 1'b1) begin $display("FAIL single_start: got %b want 1", uart_start); errors++; end
    checks++; if (uart_data_in !== 32'hDEADBEEF) begin $display("FAIL single_data: got %h want deadbeef", uart_data_in); errors++; end
    checks++; if (grant_id !== 2'd2) begin $display("FAIL single_grant: got %0d want 2", grant_id); errors++; end
    checks++; if (req_ready !== 4'b0000) begin $display("FAIL single_ready_send: got %b want 0000", req_ready); errors++; end
    req_valid = '0;
    repeat (3) begin
      tick();
      checks++;
      if (uart_start !== 1'b1 || req_done !== 4'h0) begin
        $display("FAIL single_hold: start=%b done=%b want start=1 done=0000", uart_start, req_done); errors++;
      end
    end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++; if (uart_start !== 1'b0) begin $display("FAIL single_start_drop: got %b want 0", uart_start); errors++; end
    checks++; if (req_done !== 4'b0100) begin $display("FAIL single_done: got %b want 0100", req_done); errors++; end
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (req_done !== 4'h0) pulses++;
      tick();
    end
    checks++; if (n !== GAP) begin $display("FAIL single_gap_len: got %0d want %0d", n, GAP); errors++; end
    checks++; if (pulses !== 1) begin $display("FAIL single_done_pulses: got %0d want 1", pulses); errors++; end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    auto_uart = 1'b1;
    req_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_valid = 4'hF;
    for (int f = 0; f < 6; f++) begin
      exp = f % NR;
      wait_start("rr_start");
      checks++;
      if (grant_id !== 2'(exp)) begin $display("FAIL rr_grant frame %0d: got %0d want %0d", f, grant_id, exp); errors++; end
      checks++;
      if (uart_data_in !== 32'h11111111 * (exp + 1)) begin
        $display("FAIL rr_data frame %0d: got %h want %h", f, uart_data_in, 32'h11111111 * (exp + 1)); errors++;
      end
      wait_idle("rr_idle");
    end
    req_valid = '0;
    auto_uart = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    logic [NR-1:0] seen_done = '0;
    man_done = 1'b0;
    req_data[31:0]   = 32'hA0A0A0A0;
    req_data[127:96] = 32'hD3D3D3D3;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin $display("FAIL to_ready: got %b want 1000", req_ready); errors++; end
    tick();
    checks++; if (grant_id !== 2'd3) begin $display("FAIL to_grant: got %0d want 3", grant_id); errors++; end
    while (uart_start === 1'b1 && n < 200) begin
      n++;
      seen_done = seen_done | req_done;
      tick();
    end
    seen_done = seen_done | req_done;
    checks++; if (n !== TO) begin $display("FAIL to_len: got %0d want %0d", n, TO); errors++; end
    checks++; if (timeout_err !== 4'b1000) begin $display("FAIL to_err: got %b want 1000", timeout_err); errors++; end
    checks++; if (seen_done !== 4'h0) begin $display("FAIL to_no_done: got %b want 0000", seen_done); errors++; end
    checks++; if (busy !== 1'b1) begin $display("FAIL to_busy: got %b want 1", busy); errors++; end
    tick();
    checks++; if (timeout_err !== 4'h0) begin $display("FAIL to_err_pulse: got %b want 0000", timeout_err); errors++; end
    wait_start("to_next");
    checks++; if (grant_id !== 2'd0) begin $display("FAIL to_next_grant: got %0d want 0", grant_id); errors++; end
    checks++; if (uart_data_in !== 32'hA0A0A0A0) begin $display("FAIL to_next_data: got %h want a0a0a0a0", uart_data_in); errors++; end
    req_valid = '0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++; if (req_done !== 4'b0001) begin $display("FAIL to_next_done: got %b want 0001", req_done); errors++; end
    wait_idle("to_idle");
  endtask

  task automatic test_stale_done();
    man_done = 1'b1;
    req_data[63:32] = 32'hCAFEF00D;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    checks++; if (grant_id !== 2'd1 || uart_start !== 1'b1) begin
      $display("FAIL stale_grant: grant=%0d start=%b want 1 and 1", grant_id, uart_start); errors++;
    end
    tick();
    tick();
    checks++; if (uart_start !== 1'b1 || req_done !== 4'h0) begin
      $display("FAIL stale_level: start=%b done=%b want 1 and 0000", uart_start, req_done); errors++;
    end
    man_done = 1'b0;
    tick();
    checks++; if (uart_start !== 1'b1) begin $display("FAIL stale_low: got %b want 1", uart_start); errors++; end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++; if (uart_start !== 1'b0) begin $display("FAIL stale_edge_start: got %b want 0", uart_start); errors++; end
    checks++; if (req_done !== 4'b0010) begin $display("FAIL stale_edge_done: got %b want 0010", req_done); errors++; end
    wait_idle("stale_idle");
  endtask

  task automatic test_reset_mid();
    req_data[95:64] = 32'h55AA55AA;
    req_data[31:0]  = 32'h0BADCAFE;
    req_valid = 4'b0100;
    tick();
    checks++; if (uart_start !== 1'b1) begin $display("FAIL rmid_start: got %b want 1", uart_start); errors++; end
    req_valid = 4'b0101;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (uart_start !== 1'b0) begin $display("FAIL rmid_async_start: got %b want 0", uart_start); errors++; end
    checks++; if (busy !== 1'b0 || req_ready !== 4'h0) begin
      $display("FAIL rmid_async_state: busy=%b ready=%b want 0 and 0000", busy, req_ready); errors++;
    end
    tick();
    tick();
    checks++; if (req_done !== 4'h0 || timeout_err !== 4'h0) begin
      $display("FAIL rmid_no_report: done=%b toerr=%b want 0000", req_done, timeout_err); errors++;
    end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin $display("FAIL rmid_ready: got %b want 0001", req_ready); errors++; end
    tick();
    checks++; if (grant_id !== 2'd0 || uart_data_in !== 32'h0BADCAFE) begin
      $display("FAIL rmid_first: grant=%0d data=%h want 0 and 0badcafe", grant_id, uart_data_in); errors++;
    end
    req_valid = '0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++; if (req_done !== 4'b0001) begin $display("FAIL rmid_done: got %b want 0001", req_done); errors++; end
    wait_idle("rmid_idle");
  endtask

  task automatic test_stream();
    logic [31:0] words [NR];
    logic [NR-1:0] mask;
    logic [31:0] got;
    int last = 0;
    int win;
    auto_uart = 1'b1;
    rx_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      mask = NR'($urandom_range(1, 15));
      for (int k = 0; k < NR; k++) begin
        words[k] = $urandom;
        req_data[32*k +: 32] = words[k];
      end
      win = -1;
      for (int k = 1; k <= NR; k++) begin
        if (win < 0 && mask[(last + k) % NR]) win = (last + k) % NR;
      end
      req_valid = mask;
      wait_start("stream_start");
      req_valid = '0;
      checks++;
      if (grant_id !== 2'(win)) begin $display("FAIL stream_grant %0d: got %0d want %0d", i, grant_id, win); errors++; end
      last = win;
      wait_idle("stream_idle");
      checks++;
      if (rx_q.size() == 0) begin
        $display("FAIL stream_rx %0d: got no word want %h", i, words[win]); errors++;
      end else begin
        got = rx_q.pop_front();
        if (got !== words[win]) begin $display("FAIL stream_rx %0d: got %h want %h", i, got, words[win]); errors++; end
      end
    end
    checks++; if (done_cnt !== 50) begin $display("FAIL stream_done_count: got %0d want 50", done_cnt); errors++; end
    auto_uart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stale_done();
    test_reset_mid();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
